// File: rtl/conv_window_feeder.sv
// conv_window_feeder: serial-to-parallel input stage for the convolution
// forward layer. Packs WIDTH consecutive 32-bit stream words into one vector
// and presents it with a held weight bank, a bias term and an 8-bit id.
//
// Optional feature macro: FEEDER_ZERO_PAD_EN
//   defined   - a partial vector closed by s_last is issued, with the unfilled
//               lanes forced to zero.
//   undefined - a partial vector closed by s_last is dropped and err_short
//               pulses for one cycle.
//
// Stream handshake: a word transfers on a rising edge where s_valid && s_ready.
// s_ready equals cfg_done (high in RUN, low in CFG), so the block never
// back-pressures while streaming. s_last is only sampled on a transfer.
// cfg_done also serves as the externally visible FSM state (1 = RUN).
module conv_window_feeder #(
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cfg_wr,
  input  logic [$clog2(WIDTH+1)-1:0]   cfg_addr,
  input  logic [31:0]                  cfg_data,
  input  logic                         cfg_commit,
  input  logic                         cfg_unlock,
  input  logic [31:0]                  s_data,
  input  logic                         s_valid,
  input  logic                         s_last,
  output logic                         s_ready,
  output logic [32*WIDTH-1:0]          in_data,
  output logic [32*WIDTH-1:0]          weight_vec,
  output logic [31:0]                  bias_term,
  output logic [7:0]                   id,
  output logic                         vec_valid,
  output logic                         cfg_done,
  output logic                         err_short
);

  localparam int AW = $clog2(WIDTH+1);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    ST_CFG = 1'b0,
    ST_RUN = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  logic [32*WIDTH-1:0] gather_q, gather_d;
  logic [32*WIDTH-1:0] in_data_q, in_data_d;
  logic [32*WIDTH-1:0] weight_q, weight_d;
  logic [31:0]         bias_q, bias_d;
  logic [7:0]          id_q, id_d;
  logic [7:0]          id_cnt_q, id_cnt_d;
  logic                vec_valid_q, vec_valid_d;
  logic                err_short_q, err_short_d;

  // gather buffer with the incoming word merged into its lane
  logic [32*WIDTH-1:0] lane_vec;

  // Next-state, configuration writes, gathering and vector issue.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    gather_d    = gather_q;
    in_data_d   = in_data_q;
    weight_d    = weight_q;
    bias_d      = bias_q;
    id_d        = id_q;
    id_cnt_d    = id_cnt_q;
    vec_valid_d = 1'b0;
    err_short_d = 1'b0;
    lane_vec    = gather_q;

    case (state_q)
      ST_CFG: begin
        // The write lands in the same edge as the commit, so it is not lost.
        if (cfg_wr) begin
          for (int i = 0; i < WIDTH; i++) begin
            if (cfg_addr == AW'(i)) weight_d[32*i +: 32] = cfg_data;
          end
          if (cfg_addr == AW'(WIDTH)) bias_d = cfg_data;
        end
        if (cfg_commit) state_d = ST_RUN;
      end

      ST_RUN: begin
        if (cfg_unlock) begin
          // Unlock wins over any issue; the word on this edge is dropped.
          state_d  = ST_CFG;
          count_d  = '0;
          id_cnt_d = '0;
        end else if (s_valid) begin
          for (int i = 0; i < WIDTH; i++) begin
            if (count_q == CW'(i)) lane_vec[32*i +: 32] = s_data;
          end
          gather_d = lane_vec;
          if (count_q == CW'(WIDTH-1)) begin
            in_data_d   = lane_vec;
            id_d        = id_cnt_q;
            vec_valid_d = 1'b1;
            count_d     = '0;
            id_cnt_d    = s_last ? 8'd0 : id_cnt_q + 8'd1;
          end else if (s_last) begin
`ifdef FEEDER_ZERO_PAD_EN
            in_data_d = lane_vec;
            for (int i = 0; i < WIDTH; i++) begin
              if (CW'(i) > count_q) in_data_d[32*i +: 32] = 32'h0000_0000;
            end
            id_d        = id_cnt_q;
            vec_valid_d = 1'b1;
`else
            err_short_d = 1'b1;
`endif
            count_d  = '0;
            id_cnt_d = '0;
          end else begin
            count_d = count_q + CW'(1);
          end
        end
      end

      default: state_d = ST_CFG;
    endcase
  end

  // State and datapath registers; everything clears asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_CFG;
      count_q     <= '0;
      gather_q    <= '0;
      in_data_q   <= '0;
      weight_q    <= '0;
      bias_q      <= '0;
      id_q        <= '0;
      id_cnt_q    <= '0;
      vec_valid_q <= 1'b0;
      err_short_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      gather_q    <= gather_d;
      in_data_q   <= in_data_d;
      weight_q    <= weight_d;
      bias_q      <= bias_d;
      id_q        <= id_d;
      id_cnt_q    <= id_cnt_d;
      vec_valid_q <= vec_valid_d;
      err_short_q <= err_short_d;
    end
  end

  assign s_ready    = (state_q == ST_RUN);
  assign cfg_done   = (state_q == ST_RUN);
  assign in_data    = in_data_q;
  assign weight_vec = weight_q;
  assign bias_term  = bias_q;
  assign id         = id_q;
  assign vec_valid  = vec_valid_q;
  assign err_short  = err_short_q;

endmodule

// File: tb/tb_conv_window_feeder.sv
// Testbench for conv_window_feeder (WIDTH = 8). The expected vector/error
// events come from a frame-level model (a word list per vector plus an id
// counter) and are queued; a negedge monitor pops and compares them.
module tb_conv_window_feeder;

  localparam int WIDTH = 8;
  localparam int AW    = $clog2(WIDTH+1);
  localparam int EW    = 1 + 8 + 32*WIDTH;  // {is_err, id, data}

  logic                clk;
  logic                reset;
  logic                cfg_wr;
  logic [AW-1:0]       cfg_addr;
  logic [31:0]         cfg_data;
  logic                cfg_commit;
  logic                cfg_unlock;
  logic [31:0]         s_data;
  logic                s_valid;
  logic                s_last;
  logic                s_ready;
  logic [32*WIDTH-1:0] in_data;
  logic [32*WIDTH-1:0] weight_vec;
  logic [31:0]         bias_term;
  logic [7:0]          id;
  logic                vec_valid;
  logic                cfg_done;
  logic                err_short;

  int checks   = 0;
  int failures = 0;

  logic [EW-1:0] exp_q[$];
  logic [31:0]   mdl_words[$];
  int            mdl_id;
  logic [31:0]   weights_exp[WIDTH];

  conv_window_feeder #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_wr     (cfg_wr),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .cfg_commit (cfg_commit),
    .cfg_unlock (cfg_unlock),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .in_data    (in_data),
    .weight_vec (weight_vec),
    .bias_term  (bias_term),
    .id         (id),
    .vec_valid  (vec_valid),
    .cfg_done   (cfg_done),
    .err_short  (err_short)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [32*WIDTH-1:0] pack_words();
    logic [32*WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < mdl_words.size(); i++) v[32*i +: 32] = mdl_words[i];
    return v;
  endfunction

  task automatic model_accept(input logic [31:0] d, input logic last);
    mdl_words.push_back(d);
    if (mdl_words.size() == WIDTH) begin
      exp_q.push_back({1'b0, 8'(mdl_id), pack_words()});
      mdl_id = last ? 0 : (mdl_id + 1) % 256;
      mdl_words.delete();
    end else if (last) begin
`ifdef FEEDER_ZERO_PAD_EN
      exp_q.push_back({1'b0, 8'(mdl_id), pack_words()});
`else
      exp_q.push_back({1'b1, 8'h00, {(32*WIDTH){1'b0}}});
`endif
      mdl_id = 0;
      mdl_words.delete();
    end
  endtask

  task automatic model_clear();
    mdl_words.delete();
    mdl_id = 0;
  endtask

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [EW-1:0] got, e;
    if (reset && (vec_valid || err_short)) begin
      got = {err_short, vec_valid ? id : 8'h00, vec_valid ? in_data : {(32*WIDTH){1'b0}}};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected vv=%0b err=%0b id=%0d data=%h", vec_valid, err_short, id, in_data);
      end else begin
        e = exp_q.pop_front();
        if (got !== e) begin
          failures++;
          $display("FAIL sb_event got err=%0b id=%0d data=%h exp err=%0b id=%0d data=%h",
                   got[EW-1], got[EW-2 -: 8], got[32*WIDTH-1:0],
                   e[EW-1], e[EW-2 -: 8], e[32*WIDTH-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int addr, input logic [31:0] d, input logic commit);
    cfg_wr = 1'b1; cfg_addr = AW'(addr); cfg_data = d; cfg_commit = commit;
    tick();
    cfg_wr = 1'b0; cfg_commit = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  task automatic configure();
    for (int i = 0; i < WIDTH; i++) cfg_write(i, weights_exp[i], 1'b0);
    cfg_write(WIDTH, 32'h4000_0000, 1'b1);  // bias written on the commit cycle
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic l, input logic unl);
    s_valid = v; s_data = d; s_last = l; cfg_unlock = unl;
    if (unl) model_clear();
    else if (v) model_accept(d, l);
    tick();
    s_valid = 1'b0; s_last = 1'b0; cfg_unlock = 1'b0;
  endtask

  task automatic check_cfg(input string tag);
    logic [255:0] w;
    for (int i = 0; i < WIDTH; i++) w[32*i +: 32] = weights_exp[i];
    chk({tag, "_weights"}, 256'(weight_vec), w);
    chk({tag, "_bias"}, 256'(bias_term), 256'(32'h4000_0000));
    chk({tag, "_cfg_done"}, 256'(cfg_done), 256'(1));
    chk({tag, "_s_ready"}, 256'(s_ready), 256'(1));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_in_data"}, 256'(in_data), 256'(0));
    chk({tag, "_weight_vec"}, 256'(weight_vec), 256'(0));
    chk({tag, "_bias"}, 256'(bias_term), 256'(0));
    chk({tag, "_id"}, 256'(id), 256'(0));
    chk({tag, "_vec_valid"}, 256'(vec_valid), 256'(0));
    chk({tag, "_err_short"}, 256'(err_short), 256'(0));
    chk({tag, "_s_ready"}, 256'(s_ready), 256'(0));
    chk({tag, "_cfg_done"}, 256'(cfg_done), 256'(0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; cfg_wr = 1'b0; cfg_addr = '0; cfg_data = '0;
    cfg_commit = 1'b0; cfg_unlock = 1'b0; s_data = '0; s_valid = 1'b0; s_last = 1'b0;
    mdl_id = 0;
    for (int i = 0; i < WIDTH; i++) weights_exp[i] = 32'h3F80_0000 + 32'(i) * 32'h0080_0000;
    // 1.0,2.0,3.0,... written explicitly where the simple step breaks
    weights_exp[2] = 32'h4040_0000; weights_exp[3] = 32'h4080_0000;
    weights_exp[4] = 32'h40A0_0000; weights_exp[5] = 32'h40C0_0000;
    weights_exp[6] = 32'h40E0_0000; weights_exp[7] = 32'h4100_0000;
    weights_exp[1] = 32'h4000_0000;

    #12;
    check_all_zero("reset");
    reset = 1'b1;
    tick();

    // out-of-range addresses and the stream are ignored in CFG
    for (int a = WIDTH + 1; a < (1 << AW); a++) cfg_write(a, 32'hDEAD_BEEF, 1'b0);
    drive(1'b1, 32'h1234_5678, 1'b0, 1'b0);
    mdl_words.delete();  // not accepted: s_ready is low in CFG
    exp_q.delete();
    chk("cfg_ignore_high_addr", 256'(weight_vec), 256'(0));
    chk("cfg_s_ready_low", 256'(s_ready), 256'(0));

    configure();
    check_cfg("commit");

    // writes in RUN are ignored
    cfg_write(0, 32'hFFFF_FFFF, 1'b0);
    cfg_write(WIDTH, 32'hFFFF_FFFF, 1'b0);
    check_cfg("run_wr_ignored");

    // two back-to-back vectors 0..15
    for (int i = 0; i < 16; i++) drive(1'b1, 32'(i), 1'b0, 1'b0);

    // short frame: 3 words with s_last, then a full frame starting at id 0
    for (int i = 0; i < 3; i++) drive(1'b1, 32'h100 + 32'(i), i == 2, 1'b0);
    for (int i = 0; i < 8; i++) drive(1'b1, 32'h200 + 32'(i), i == 7, 1'b0);

    // 257 full vectors without s_last: id wraps
    for (int i = 0; i < 257 * WIDTH; i++) drive(1'b1, $urandom, 1'b0, 1'b0);
    drive(1'b1, 32'hABCD_0000, 1'b1, 1'b0);  // close the frame (short)

    // unlock after 5 words; the word on the unlock edge is discarded
    for (int i = 0; i < 5; i++) drive(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0);
    drive(1'b1, 32'h3FF, 1'b0, 1'b1);
    chk("unlock_cfg_done", 256'(cfg_done), 256'(0));
    chk("unlock_s_ready", 256'(s_ready), 256'(0));
    commit();
    check_cfg("recommit");
    for (int i = 0; i < 8; i++) drive(1'b1, 32'h400 + 32'(i), 1'b0, 1'b0);

    // unlock on the very edge that would complete a vector
    for (int i = 0; i < 7; i++) drive(1'b1, 32'h500 + 32'(i), 1'b0, 1'b0);
    drive(1'b1, 32'h5FF, 1'b0, 1'b1);
    commit();

    // randomized frames with gaps
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) drive(1'b0, $urandom, 1'b0, 1'b0);
      else drive(1'b1, $urandom, $urandom_range(0, 9) == 0, 1'b0);
    end

    // reset after 4 words, asserted between edges
    for (int i = 0; i < 4; i++) drive(1'b1, 32'h600 + 32'(i), 1'b0, 1'b0);
    @(negedge clk); #1;
    reset = 1'b0;
    #1;
    check_all_zero("midreset");
    model_clear();
    tick();
    reset = 1'b1;
    tick();
    configure();
    check_cfg("reconfig");
    for (int i = 0; i < 8; i++) drive(1'b1, 32'h700 + 32'(i), 1'b0, 1'b0);

    // drain: bounded wait for all expected events
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    tick();
    chk("sb_drained", 256'(exp_q.size()), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
